// File: rtl/aiken_pkg.sv
// Shared definitions for the BCD-to-Aiken word sequencer.
//   state_e              : sequencer states (IDLE / CONV / HOLD)
//   AIKEN_NDIG_DEFAULT   : default number of BCD digits per word
//   AIKEN_INVALID_NIBBLE : code emitted for a digit outside 0..9
package aiken_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned AIKEN_NDIG_DEFAULT   = 4;
    localparam logic [3:0]  AIKEN_INVALID_NIBBLE = 4'b0000;

endpackage

// File: rtl/aiken_word_seq_b2aik.sv
// b2aik: combinational single-digit BCD to Aiken (2421) converter.
//   bcd     : input BCD digit
//   aiken   : 2421 code (0-4 unchanged, 5-9 -> value+6), invalid code for 10-15
//   invalid : digit was greater than 9
module b2aik
    import aiken_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] aiken,
    output logic       invalid
);

    always_comb begin
        invalid = 1'b0;
        aiken   = bcd;
        if (bcd > 4'd9) begin
            invalid = 1'b1;
            aiken   = AIKEN_INVALID_NIBBLE;
        end else if (bcd > 4'd4) begin
            aiken = bcd + 4'd6;
        end
    end

endmodule

// File: rtl/aiken_word_seq.sv
// aiken_word_seq: converts a word of NDIG BCD digits into Aiken (2421) code,
// one digit per cycle through a single shared b2aik converter.
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid/in_ready/in_word
//                           : input handshake; accepted only in IDLE
//   out_valid/out_ready     : output handshake; result held in HOLD
//   out_aiken               : converted word, same digit order as in_word
//   out_err_mask, out_err   : per-digit invalid flags and their OR
//   err_cnt                 : saturating count of delivered words with out_err
module aiken_word_seq
    import aiken_pkg::*;
#(
    parameter int unsigned NDIG = AIKEN_NDIG_DEFAULT,
    parameter int unsigned CNTW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_aiken,
    output logic [NDIG-1:0]   out_err_mask,
    output logic              out_err,
    output logic [CNTW-1:0]   err_cnt
);

    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [4*NDIG-1:0] word_q, word_d;
    logic [4*NDIG-1:0] aiken_q, aiken_d;
    logic [NDIG-1:0]   mask_q, mask_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [3:0]        cur_digit;
    logic [3:0]        cur_nibble;
    logic              cur_invalid;

    always_comb begin
        cur_digit = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (idx_q == IDXW'(i)) cur_digit = word_q[4*i +: 4];
        end
    end

    b2aik u_b2aik (
        .bcd     (cur_digit),
        .aiken   (cur_nibble),
        .invalid (cur_invalid)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        aiken_d = aiken_q;
        mask_d  = mask_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    word_d  = in_word;
                    idx_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int unsigned i = 0; i < NDIG; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        aiken_d[4*i +: 4] = cur_nibble;
                        mask_d[i]         = cur_invalid;
                    end
                end
                // Tracks the mask as it fills, so it is final on entry to HOLD.
                err_d = |mask_d;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(NDIG - 1)) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (err_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state.
        valid_d = (state_d == HOLD);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            aiken_q <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            aiken_q <= aiken_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = valid_q;
    assign out_aiken    = aiken_q;
    assign out_err_mask = mask_q;
    assign out_err      = err_q;
    assign err_cnt      = cnt_q;

endmodule

// File: doc/aiken_word_seq.md
AIKEN_WORD_SEQ -- requirements
Module: aiken_word_seq

Interface
REQ-001 SHALL have parameter NDIG, default 4, the number of BCD digits per word (range 1..8).
REQ-002 SHALL have parameter CNTW, default 8, the width of the error-word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning in_word is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts in_word this cycle.
REQ-007 SHALL have port in_word, input, 4*NDIG, the BCD word; digit i is bits [4i+3:4i].
REQ-008 SHALL have port out_valid, output, 1, meaning the result fields are valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 SHALL have port out_aiken, output, 4*NDIG, the Aiken (2421) word, with the same digit order as in_word.
REQ-011 SHALL have port out_err_mask, output, NDIG, where bit i is set if digit i was greater than 9.
REQ-012 SHALL have port out_err, output, 1, the OR of out_err_mask.
REQ-013 SHALL have port err_cnt, output, CNTW, a saturating count of delivered words whose out_err is 1.

Function
REQ-014 SHALL time-share exactly one b2aik converter instance across all digits, converting one digit per cycle.
REQ-015 SHALL implement a state machine with three states: IDLE, CONV and HOLD.
REQ-016 SHALL drive in_ready to 1 only in IDLE; an input transfer occurs on an edge where in_valid=1 and in_ready=1.
REQ-017 SHALL, on an input transfer, capture in_word, clear the digit index to 0 and enter CONV.
REQ-018 SHALL, in CONV, present digit[index] to b2aik and register its result into nibble[index] and its invalid flag into mask[index] on each edge.
REQ-019 SHALL, in CONV, increment the index on each edge, and move to HOLD on the edge that processes index NDIG-1.
REQ-020 SHALL use the conversion 0-4 -> 0000-0100 and 5-9 -> 1011-1111.
REQ-021 SHALL, for an invalid digit (10-15), force the nibble to 0000 and set its mask bit.
REQ-022 SHALL assert out_valid exactly NDIG cycles after the accepting edge, and only in HOLD.
REQ-023 SHALL keep out_aiken, out_err_mask and out_err stable while out_valid=1 and out_ready=0, for any duration.
REQ-024 SHALL complete an output transfer on an edge where out_valid=1 and out_ready=1, then return to IDLE, making in_ready=1 in the next cycle.
REQ-025 SHALL NOT allow a second input to overlap a conversion: in_valid is ignored in CONV and HOLD, and in_word changes there have no effect.
REQ-026 SHALL complete the transfer in the first cycle if out_ready is already 1 when out_valid first rises.
REQ-027 SHALL increment err_cnt by 1 on an output transfer with out_err=1, saturating at 2^CNTW-1 with no wrap.
REQ-028 SHALL hold out_aiken and out_err_mask at their last values outside HOLD; they carry no meaning there.

Reset
REQ-029 SHALL, on an edge with rst_n=0, enter IDLE, set the index to 0, set out_valid to 0, in_ready to 1 (once released), out_aiken to 0, out_err_mask to 0, out_err to 0 and err_cnt to 0.
REQ-030 SHALL, on reset during CONV or HOLD, abandon the word in flight: no output transfer occurs for it and err_cnt is not updated.

Structure
REQ-031 SHALL place the state enum (IDLE/CONV/HOLD), the default NDIG, and the constant AIKEN_INVALID_NIBBLE = 4'b0000 in a shared package aiken_pkg.
REQ-032 SHALL instantiate the existing b2aik module as its only sub-module, as a single instance; no other hierarchy.

Verification
REQ-033 SHALL verify: in_word=16'h1234 accepted -> out_valid after 4 cycles, out_aiken=16'h1234, out_err_mask=4'b0000, out_err=0.
REQ-034 SHALL verify: in_word=16'h5678 -> out_aiken=16'hBCDE, out_err=0.
REQ-035 SHALL verify: in_word=16'h9A09 -> out_aiken=16'hF00F, out_err_mask=4'b0100, out_err=1, and err_cnt becomes 1 after the transfer.
REQ-036 SHALL verify: out_ready held at 0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; transfer on the 6th cycle, then in_ready=1 in the next cycle.
REQ-037 SHALL verify: rst_n=0 for one edge at index 2 of CONV -> IDLE, out_valid=0, err_cnt unchanged at 0; the next word 16'h0009 converts to 16'h000F.
REQ-038 SHALL verify: with CNTW=2, five words containing an invalid digit -> err_cnt reads 1, 2, 3, 3, 3.
